// File: rtl/vec_mac_acc.sv
// vec_mac_acc: streaming multi-beat dot-product engine (product reg, adder tree, accumulator).
// Define VEC_MAC_SAT_EN to clamp results into W_Y bits; otherwise results wrap.
module vec_mac_acc #(
    parameter int C         = 16,
    parameter int W_X       = 32,
    parameter int W_K       = 32,
    parameter int W_Y       = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic               mode_signed,
    input  logic [C*W_X-1:0]   x,
    input  logic [C*W_K-1:0]   k,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W_Y-1:0]     m_data,
    output logic               m_sat
);
    localparam int W_P   = W_X + W_K + 2;
    localparam int LG_C  = $clog2(C);
    localparam int W_T   = W_P + LG_C;
    localparam int LG_B  = $clog2(MAX_BEATS);
    localparam int W_ACC = W_T + LG_B;
    localparam int CW    = (LG_B > 0) ? LG_B : 1;

    logic          stall, accept, last_in, mode_in, out_load;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          first_d, first_q, vmode_d, vmode_q;

    // Heap-ordered tree: leaves C..2C-1 hold products, node n sums 2n and 2n+1.
    logic signed [W_T-1:0] node_d [1:2*C-1];
    logic signed [W_T-1:0] node_q [1:2*C-1];

    logic [LG_C:0] tv_d, tv_q, tf_d, tf_q, tl_d, tl_q, tm_d, tm_q;

    logic signed [W_ACC-1:0] acc_d, acc_q;
    logic                    av_d, av_q, al_d, al_q, am_d, am_q;

    logic           m_valid_d, m_valid_q, m_sat_d, m_sat_q, red_sat;
    logic [W_Y-1:0] m_data_d, m_data_q, red_data;

    always_comb begin : ctl
        stall   = m_valid_q && !m_ready;
        s_ready = !rst && !stall;
        accept  = s_valid && s_ready;
        last_in = s_last || (cnt_q == CW'(MAX_BEATS - 1));
        mode_in = first_q ? mode_signed : vmode_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        vmode_d = vmode_q;
        if (accept) begin
            cnt_d   = last_in ? '0 : cnt_q + 1'b1;
            first_d = last_in;
            vmode_d = mode_in;
        end
    end

    always_comb begin : tree
        logic signed [W_X:0]   xe;
        logic signed [W_K:0]   ke;
        logic signed [W_P-1:0] p;
        xe = '0;
        ke = '0;
        p  = '0;
        for (int n = 1; n < C; n++) begin
            node_d[n] = node_q[2*n] + node_q[2*n+1];
        end
        for (int i = 0; i < C; i++) begin
            xe = {mode_in & x[i*W_X+W_X-1], x[i*W_X +: W_X]};
            ke = {mode_in & k[i*W_K+W_K-1], k[i*W_K +: W_K]};
            p  = W_P'(xe) * W_P'(ke);
            node_d[C+i] = W_T'(p);
        end
    end

    always_comb begin : tags
        tv_d = {tv_q[LG_C-1:0], accept};
        tf_d = {tf_q[LG_C-1:0], first_q};
        tl_d = {tl_q[LG_C-1:0], last_in};
        tm_d = {tm_q[LG_C-1:0], mode_in};
    end

    always_comb begin : stage_a
        acc_d = acc_q;
        av_d  = av_q;
        al_d  = al_q;
        am_d  = am_q;
        if (!stall) begin
            av_d = tv_q[LG_C];
            al_d = tl_q[LG_C];
            am_d = tm_q[LG_C];
            if (tv_q[LG_C]) begin
                acc_d = tf_q[LG_C] ? W_ACC'(node_q[1])
                                   : acc_q + W_ACC'(node_q[1]);
            end
        end
    end

`ifdef VEC_MAC_SAT_EN
    localparam logic signed [W_ACC-1:0] SMAX =
        {{(W_ACC-W_Y+1){1'b0}}, {(W_Y-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] SMIN =
        {{(W_ACC-W_Y+1){1'b1}}, {(W_Y-1){1'b0}}};
    localparam logic signed [W_ACC-1:0] UMAX =
        {{(W_ACC-W_Y){1'b0}}, {W_Y{1'b1}}};

    always_comb begin : reduce
        red_data = acc_q[W_Y-1:0];
        red_sat  = 1'b0;
        if (am_q) begin
            if (acc_q > SMAX) begin
                red_data = SMAX[W_Y-1:0];
                red_sat  = 1'b1;
            end else if (acc_q < SMIN) begin
                red_data = SMIN[W_Y-1:0];
                red_sat  = 1'b1;
            end
        end else if (acc_q > UMAX) begin
            red_data = UMAX[W_Y-1:0];
            red_sat  = 1'b1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{am_q, acc_q[W_ACC-1:W_Y]};

    always_comb begin : reduce
        red_data = acc_q[W_Y-1:0];
        red_sat  = 1'b0;
    end
`endif

    always_comb begin : out_reg
        out_load  = !stall && av_q && al_q;
        m_valid_d = out_load ? 1'b1 : (m_ready ? 1'b0 : m_valid_q);
        m_data_d  = out_load ? red_data : m_data_q;
        m_sat_d   = out_load ? red_sat : m_sat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            first_q   <= 1'b1;
            vmode_q   <= 1'b0;
            for (int n = 1; n < 2*C; n++) node_q[n] <= '0;
            tv_q      <= '0;
            tf_q      <= '0;
            tl_q      <= '0;
            tm_q      <= '0;
            acc_q     <= '0;
            av_q      <= 1'b0;
            al_q      <= 1'b0;
            am_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sat_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
            vmode_q <= vmode_d;
            if (!stall) begin
                for (int n = 1; n < 2*C; n++) node_q[n] <= node_d[n];
                tv_q <= tv_d;
                tf_q <= tf_d;
                tl_q <= tl_d;
                tm_q <= tm_d;
            end
            acc_q     <= acc_d;
            av_q      <= av_d;
            al_q      <= al_d;
            am_q      <= am_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sat_q   <= m_sat_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sat   = m_sat_q;
endmodule
